// File: rtl/uart_xmit.sv
// uart_xmit: 8N1 LSB-first UART transmitter with a one-entry holding register for gap-free streaming
module uart_xmit #(
  parameter int baudrate        = 115200,
  parameter int clock_frequency = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dat,
  input  logic       dat_en,
  output logic       rdy,
  output logic       tx,
  output logic       busy
);
  localparam int CLKS_PER_BIT = clock_frequency / baudrate;
  localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 2) begin : g_bad_rate
    $error("uart_xmit: clock_frequency / baudrate must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, hold;
  logic          hold_full, load, tx_n, last, accept;

  assign last   = cnt == CW'(CLKS_PER_BIT - 1);
  assign accept = dat_en & ~hold_full;
  assign rdy    = ~hold_full;
  assign busy   = (state != IDLE) | hold_full;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // next state, next line level, bit timing; load pulls the held byte into the shifter
  always_comb begin
    state_n = state;
    cnt_n   = last ? '0 : cnt + 1'b1;
    idx_n   = idx;
    tx_n    = tx;
    load    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        tx_n  = 1'b1;
        if (hold_full) begin
          load    = 1'b1;
          state_n = START_BIT;
          tx_n    = 1'b0;
        end
      end
      START_BIT: begin
        if (last) begin
          state_n = DATA_BITS;
          idx_n   = 3'd0;
          tx_n    = shift[0];
        end
      end
      DATA_BITS: begin
        if (last) begin
          if (idx == 3'd7) begin
            state_n = STOP_BIT;
            tx_n    = 1'b1;
          end else begin
            idx_n = idx + 3'd1;
            tx_n  = shift[idx + 3'd1];
          end
        end
      end
      STOP_BIT: begin
        if (last) begin
          if (hold_full) begin
            load    = 1'b1;
            state_n = START_BIT;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // line register, counters and shifter; tx is registered so it cannot glitch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx    <= 1'b1;
      cnt   <= '0;
      idx   <= 3'd0;
      shift <= 8'd0;
    end else begin
      tx    <= tx_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= load ? hold : shift;
    end
  end

  // holding register: filled on accept, emptied when the shifter takes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold      <= 8'd0;
      hold_full <= 1'b0;
    end else begin
      hold      <= accept ? dat : hold;
      hold_full <= load ? 1'b0 : (accept | hold_full);
    end
  end
endmodule

// File: tb/tb_uart_xmit.sv
// tb_uart_xmit: frame-schedule model plus loopback receiver checking uart_xmit every cycle
module tb_uart_xmit;
  localparam int CPB = 10;
  localparam int FL  = 10 * CPB;

  logic       clk = 1'b0, reset = 1'b1;
  logic [7:0] dat = 8'd0, dat1 = 8'd0;
  logic       dat_en = 1'b0, dat_en1 = 1'b0;
  logic       rdy, tx, busy, rdy1, tx1, busy1;

  always #5 clk = ~clk;

  uart_xmit #(.baudrate(10), .clock_frequency(100)) u0 (
    .clk(clk), .reset(reset), .dat(dat), .dat_en(dat_en), .rdy(rdy), .tx(tx), .busy(busy));
  uart_xmit #(.baudrate(50), .clock_frequency(100)) u1 (
    .clk(clk), .reset(reset), .dat(dat1), .dat_en(dat_en1), .rdy(rdy1), .tx(tx1), .busy(busy1));

  typedef struct {int acc; int s; logic [7:0] d;} fr_t;
  fr_t        fq[$];
  logic [7:0] exp_rx[$];
  int         cyc = 0, last_end = 0, ns;
  int         n_chk = 0, n_fail = 0;
  fr_t        f;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic m_held(input int t);
    foreach (fq[i]) if (fq[i].acc <= t && t < fq[i].s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_busy(input int t);
    foreach (fq[i]) if (fq[i].acc <= t && t < fq[i].s + FL) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_tx(input int t);
    int k;
    foreach (fq[i]) if (t >= fq[i].s && t < fq[i].s + FL) begin
      k = (t - fq[i].s) / CPB;
      return (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : fq[i].d[k-1];
    end
    return 1'b1;
  endfunction

  // model: each accepted byte gets a frame slot starting the edge after accept or at the end of the previous frame
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fq.delete();
      exp_rx.delete();
      cyc = 0;
      last_end = 0;
    end else begin
      cyc++;
      if (dat_en && !m_held(cyc - 1)) begin
        ns = (cyc + 1 > last_end) ? cyc + 1 : last_end;
        f.acc = cyc; f.s = ns; f.d = dat;
        fq.push_back(f);
        exp_rx.push_back(dat);
        last_end = ns + FL;
      end
      while (fq.size() > 0 && fq[0].s + FL < cyc - 2) void'(fq.pop_front());
    end
  end

  // per-cycle compare of u0 outputs against the model
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_tx", tx, 1); chk("rst_rdy", rdy, 1); chk("rst_busy", busy, 0);
    end else begin
      chk("tx", tx, m_tx(cyc)); chk("rdy", rdy, !m_held(cyc)); chk("busy", busy, m_busy(cyc));
    end
  end

  // loopback receiver sampling mid-bit
  logic       rx_act = 1'b0;
  int         rx_cnt = 0, rx_n = 0;
  logic [7:0] rx_sh;
  always @(negedge clk) begin
    if (reset) rx_act = 1'b0;
    else if (!rx_act) begin
      if (tx === 1'b0) begin rx_act = 1'b1; rx_cnt = 0; end
    end else begin
      rx_cnt++;
      if (rx_cnt > 5 && rx_cnt < 95 && rx_cnt % 10 == 5) rx_sh = {tx, rx_sh[7:1]};
      if (rx_cnt == 95) begin
        rx_act = 1'b0;
        rx_n++;
        chk("rx_stop", tx, 1);
        if (exp_rx.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rx_unexpected: got %0h expected no byte", rx_sh);
        end else chk("rx_byte", rx_sh, exp_rx.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (m_held(cyc) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin n_chk++; n_fail++; $display("FAIL send_timeout: got held expected rdy"); end
    dat = b; dat_en = 1'b1;
    @(negedge clk);
    dat_en = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    int n = 0;
    while (cyc < t && n < 5000) begin @(negedge clk); n++; end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_busy(cyc) || rx_act) && n < 40000) begin @(negedge clk); n++; end
    if (n >= 40000) begin n_chk++; n_fail++; $display("FAIL idle_timeout: got busy expected idle"); end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int k, base;
    logic [9:0] l1, l6;
    l1 = 10'b1101001010;
    l6 = 10'b1100000010;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t1_idle_tx", tx, 1); chk("t1_idle_rdy", rdy, 1); chk("t1_idle_busy", busy, 0);
    send(8'hA5); k = cyc;
    for (int j = 0; j < 10; j++) begin
      wait_cyc(k + 6 + 10 * j);
      chk("t1_line", tx, l1[j]);
    end
    wait_cyc(k + 100); chk("t1_busy_last", busy, 1);
    wait_cyc(k + 101); chk("t1_busy_done", busy, 0);
    wait_idle();
    base = rx_n;
    send(8'h00); k = cyc;
    send(8'hFF);
    chk("t2_rdy_held", rdy, 0);
    dat = 8'h5A; dat_en = 1'b1;
    @(negedge clk);
    dat_en = 1'b0;
    wait_cyc(k + 100); chk("t2_stop", tx, 1);
    wait_cyc(k + 101); chk("t2_nogap_start", tx, 0);
    wait_idle();
    chk("t3_rx_count", rx_n - base, 2);
    send(8'h3C); k = cyc;
    wait_cyc(k + 26);
    chk("t4_pre_tx", tx, 0);
    #2 reset = 1'b1;
    #1;
    chk("t4_rst_tx", tx, 1); chk("t4_rst_rdy", rdy, 1); chk("t4_rst_busy", busy, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("t4_quiet_tx", tx, 1); chk("t4_quiet_busy", busy, 0);
    base = rx_n;
    for (int i = 0; i < 256; i++) send(8'($urandom_range(0, 255)));
    wait_idle();
    chk("t5_rx_count", rx_n - base, 256);
    chk("t5_rx_left", exp_rx.size(), 0);
    dat1 = 8'h81; dat_en1 = 1'b1;
    @(negedge clk);
    dat_en1 = 1'b0;
    chk("t6_rdy_held", rdy1, 0); chk("t6_tx_idle", tx1, 1);
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      chk("t6_line", tx1, l6[j / 2]);
    end
    @(negedge clk);
    chk("t6_busy_done", busy1, 0); chk("t6_tx_done", tx1, 1); chk("t6_rdy_done", rdy1, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
